// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit -- instruction fetch stage of the pipelined MIPS CPU.
//
// Owns the PC and issues one word fetch at a time to instruction memory over a
// req/ready + rvalid handshake (wait states allowed, one request in flight).
// Up to two fetched instructions are buffered with their PC+4. The head of the
// buffer feeds the IF/ID register. Branch/jump redirects flush the buffer and
// discard any fetch still in flight.
//
// Optional build macro: IF_PERF_CNT_EN adds the fetch_count/bubble_count
// performance counter outputs.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall             downstream is not consuming this cycle
//   branch_taken      one-cycle redirect pulse
//   branch_target     redirect PC (low two bits ignored)
//   imem_req/addr     fetch request and word-aligned byte address
//   imem_ready        memory accepts the request this cycle
//   imem_rvalid/rdata fetch response
//   inst_out/pc4_out  head instruction and its address plus 4
//   inst_valid        inst_out/pc4_out hold a real instruction
//   fetch_count       (IF_PERF_CNT_EN) instructions pushed into the buffer
//   bubble_count      (IF_PERF_CNT_EN) cycles with no instruction and no stall
// -----------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_out,
   output logic [31:0] pc4_out,
   output logic        inst_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] bubble_count
`endif
);

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_FULL, S_DRAIN} state_t;

   state_t      state;
   logic [31:0] pc;

   // two-entry buffer of {instruction, pc+4}
   logic [31:0] buf_inst [2];
   logic [31:0] buf_pc4  [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic [1:0]  count_nxt;

   logic        accept;
   logic        pop;
   logic        push;
   logic [31:0] redirect_pc;

   assign inst_valid  = (count != 2'd0);
   assign inst_out    = inst_valid ? buf_inst[rd_ptr] : NOP_WORD;
   assign pc4_out     = inst_valid ? buf_pc4[rd_ptr]  : 32'h0;

   // Gated by rst so the request stays low while reset is held, yet rises in
   // the very first cycle after reset is released.
   assign imem_req    = (state == S_FETCH) && !rst;
   assign imem_addr   = pc;
   assign accept      = imem_req && imem_ready;

   // A redirect flushes the buffer, so neither pop nor push may happen with it.
   assign pop         = inst_valid && !stall && !branch_taken;
   // Only a response to a live request is kept; DRAIN responses are dropped.
   assign push        = (state == S_WAIT) && imem_rvalid && !branch_taken;
   assign count_nxt   = count + {1'b0, push} - {1'b0, pop};
   assign redirect_pc = branch_target & ~32'h3;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_FETCH;
         pc     <= RESET_PC;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (branch_taken) begin
         pc     <= redirect_pc;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
         case (state)
            // If the outstanding response lands in the redirect cycle itself
            // it is discarded here and nothing is left to drain.
            S_WAIT,
            S_DRAIN: state <= imem_rvalid ? S_FETCH : S_DRAIN;
            S_FETCH: state <= accept ? S_DRAIN : S_FETCH;
            default: state <= S_FETCH;
         endcase
      end else begin
         if (accept) pc <= pc + 32'd4;
         if (pop)    rd_ptr <= ~rd_ptr;
         if (push)   wr_ptr <= ~wr_ptr;
         count <= count_nxt;
         case (state)
            S_FETCH: if (accept) state <= S_WAIT;
            // Refetch only if a slot will still be free after this push.
            S_WAIT:  if (imem_rvalid) state <= (count_nxt == 2'd2) ? S_FULL : S_FETCH;
            S_FULL:  if (pop) state <= S_FETCH;
            S_DRAIN: if (imem_rvalid) state <= S_FETCH;
            default: state <= S_FETCH;
         endcase
      end
   end

   // In WAIT the PC has already advanced past the outstanding word, so it is
   // exactly that word's pc+4.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         buf_inst[wr_ptr] <= imem_rdata;
         buf_pc4[wr_ptr]  <= pc;
      end
   end

`ifdef IF_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count  <= 32'h0;
         bubble_count <= 32'h0;
      end else begin
         if (push)                 fetch_count  <= fetch_count + 32'd1;
         if (!inst_valid && !stall) bubble_count <= bubble_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_unit -- directed bench for if_fetch_unit.
//
// A memory responder answers each accepted fetch after a programmable latency
// with data = addr ^ 32'hC0DE_0000. A queue-based reference model predicts the
// outputs every cycle; literal checks along the directed sequence pin it.
// -----------------------------------------------------------------------------
module tb_if_fetch_unit;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] inst_out;
   logic [31:0] pc4_out;
   logic        inst_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] bubble_count;
`endif

   if_fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ready    (imem_ready),
      .imem_rvalid   (imem_rvalid),
      .imem_rdata    (imem_rdata),
      .inst_out      (inst_out),
      .pc4_out       (pc4_out),
      .inst_valid    (inst_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .fetch_count   (fetch_count),
      .bubble_count  (bubble_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;
   int lat    = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   int          mem_cnt;
   logic [31:0] mem_addr;
   logic        s_acc;
   logic        s_rst;
   logic [31:0] s_addr;
   int          s_lat;

   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      mem_cnt     = 0;
      mem_addr    = 32'h0;
      forever begin
         @(negedge clk);
         s_acc  = imem_req && imem_ready;
         s_addr = imem_addr;
         s_lat  = lat;
         s_rst  = rst;
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         if (s_rst) begin
            mem_cnt = 0;
         end else begin
            if (s_acc) begin
               mem_cnt  = s_lat;
               mem_addr = s_addr;
            end
            if (mem_cnt > 0) begin
               mem_cnt--;
               if (mem_cnt == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = mem_addr ^ 32'hC0DE_0000;
               end
            end
         end
      end
   end

   // ---------------- reference model ----------------
   // Fetch rule: request whenever nothing is in flight and the buffer has room.
   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
   } ent_t;

   ent_t        mq[$];
   bit          m_out;       // a request is in flight
   bit          m_drop;      // its response must be discarded
   logic [31:0] m_pc;
   logic [31:0] m_pend_pc4;
   logic [31:0] m_fc;
   logic [31:0] m_bc;

   initial begin
      bit   req;
      bit   acc;
      ent_t e;
      m_out = 0; m_drop = 0; m_pc = 32'h0; m_pend_pc4 = 32'h0; m_fc = 0; m_bc = 0;
      forever begin
         @(posedge clk);
         if (rst) begin
            mq.delete();
            m_out = 0; m_drop = 0; m_pc = 32'h0; m_fc = 0; m_bc = 0;
         end else begin
            req = !m_out && (mq.size() < 2);
            acc = req && imem_ready;
            if (mq.size() == 0 && !stall) m_bc = m_bc + 1;
            if (branch_taken) begin
               mq.delete();
               m_out  = (m_out && !imem_rvalid) || acc;
               m_drop = m_out;
               m_pc   = {branch_target[31:2], 2'b00};
            end else begin
               if (mq.size() > 0 && !stall) void'(mq.pop_front());
               if (m_out && imem_rvalid) begin
                  if (!m_drop) begin
                     e.inst = imem_rdata;
                     e.pc4  = m_pend_pc4;
                     mq.push_back(e);
                     m_fc = m_fc + 1;
                  end
                  m_out  = 0;
                  m_drop = 0;
               end
               if (acc) begin
                  m_out      = 1;
                  m_pend_pc4 = m_pc + 32'd4;
                  m_pc       = m_pc + 32'd4;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("m_req",   imem_req,   (!rst && !m_out && mq.size() < 2) ? 32'd1 : 32'd0);
            chk("m_addr",  imem_addr,  m_pc);
            chk("m_valid", inst_valid, (mq.size() > 0) ? 32'd1 : 32'd0);
            chk("m_inst",  inst_out,   (mq.size() > 0) ? mq[0].inst : 32'h0);
            chk("m_pc4",   pc4_out,    (mq.size() > 0) ? mq[0].pc4  : 32'h0);
`ifdef IF_PERF_CNT_EN
            chk("m_fcnt",  fetch_count,  m_fc);
            chk("m_bcnt",  bubble_count, m_bc);
`endif
         end
      end
   end

   // ---------------- directed sequence ----------------
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
      imem_ready = 1'b1; lat = 1;
      nxt();
      cmp_en = 1'b1;
      nxt();
      chk("rst_req",   imem_req,   0);
      chk("rst_addr",  imem_addr,  0);
      chk("rst_valid", inst_valid, 0);
      chk("rst_inst",  inst_out,   0);
      chk("rst_pc4",   pc4_out,    0);
      rst = 1'b0;                                    // c0
      #1;
      chk("c0_req",  imem_req,  1);
      chk("c0_addr", imem_addr, 0);
      nxt();                                         // c1
      #1 chk("c1_valid", inst_valid, 0);
      nxt();                                         // c2
      stall = 1'b1;
      #1;
      chk("c2_valid", inst_valid, 1);
      chk("c2_pc4",   pc4_out,    32'h4);
      chk("c2_inst",  inst_out,   32'hC0DE_0000);
      repeat (3) nxt();                              // c5: buffer full
      #1;
      chk("full_req",  imem_req, 0);
      chk("full_inst", inst_out, 32'hC0DE_0000);
      chk("full_pc4",  pc4_out,  32'h4);
      repeat (3) nxt();                              // c8: release stall
      stall = 1'b0;
      #1 chk("c8_pc4", pc4_out, 32'h4);
      nxt();                                         // c9: memory not ready
      imem_ready = 1'b0;
      #1;
      chk("c9_pc4",  pc4_out,   32'h8);
      chk("c9_addr", imem_addr, 32'h8);
      repeat (2) nxt();                              // c11
      #1;
      chk("nrdy_addr",  imem_addr,  32'h8);
      chk("nrdy_req",   imem_req,   1);
      chk("nrdy_valid", inst_valid, 0);
      nxt();                                         // c12
      imem_ready = 1'b1;
      repeat (2) nxt();                              // c14
      lat = 3;
      #1 chk("c14_pc4", pc4_out, 32'hC);
      nxt();                                         // c15: redirect in WAIT
      branch_taken = 1'b1; branch_target = 32'h0040_0103;
      nxt();                                         // c16
      branch_taken = 1'b0;
      #1;
      chk("br_valid", inst_valid, 0);
      chk("br_req",   imem_req,   0);
      repeat (2) nxt();                              // c18
      #1;
      chk("br_addr", imem_addr, 32'h0040_0100);
      chk("br_req2", imem_req,  1);
      nxt();                                         // c19
      lat = 1;
      repeat (3) nxt();                              // c22
      stall = 1'b1;
      #1;
      chk("tgt_pc4",  pc4_out,  32'h0040_0104);
      chk("tgt_inst", inst_out, 32'hC09E_0100);
      repeat (2) nxt();                              // c24
      #1;
      chk("f2_valid", inst_valid, 1);
      chk("f2_req",   imem_req,   0);
      nxt();                                         // c25: redirect + stall, full
      branch_taken = 1'b1; branch_target = 32'h0000_1000;
      nxt();                                         // c26
      branch_taken = 1'b0; stall = 1'b0;
      #1;
      chk("bs_valid", inst_valid, 0);
      chk("bs_addr",  imem_addr,  32'h0000_1000);
      chk("bs_req",   imem_req,   1);
      nxt();                                         // c27
      lat = 3;
      nxt();                                         // c28
      #1 chk("bs_pc4", pc4_out, 32'h0000_1004);
      nxt();                                         // c29: reset during WAIT
      rst = 1'b1;
      nxt();                                         // c30
      #1;
      chk("r2_req",   imem_req,   0);
      chk("r2_addr",  imem_addr,  0);
      chk("r2_valid", inst_valid, 0);
      chk("r2_inst",  inst_out,   0);
      chk("r2_pc4",   pc4_out,    0);
`ifdef IF_PERF_CNT_EN
      chk("r2_fcnt", fetch_count,  0);
      chk("r2_bcnt", bubble_count, 0);
`endif
      nxt();                                         // c31
      rst = 1'b0;
      lat = 1;
      #1;
      chk("r2_req1",  imem_req,  1);
      chk("r2_addr1", imem_addr, 0);
      repeat (2) nxt();                              // c33
      #1 chk("r2_pc4b", pc4_out, 32'h4);
      repeat (6) nxt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
